mem_rr_scheduler: RTL

- Round-robin scheduler that shares the single data-memory port between core 0 and core 1 of the dual-core RV32 system.
- Each core has a valid/ready request channel and a one-cycle response pulse. Requests are registered, then issued to a memory port that may take several cycles to acknowledge.
- Supports a bus lock so one core can perform an atomic read-modify-write without interleaving.
- A watchdog returns an error response if memory never acknowledges.

---
 rtl/mem_rr_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_rr_scheduler.sv
// Round-robin arbiter sharing one data-memory port between two cores, with a
// bus lock for atomic sequences and a watchdog that aborts unacknowledged accesses.
module mem_rr_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core0_req_valid,
    output logic        core0_req_ready,
    input  logic [31:0] core0_addr,
    input  logic [31:0] core0_wdata,
    input  logic [2:0]  core0_funct3,
    input  logic        core0_we,
    input  logic        core0_lock,
    output logic        core0_rsp_valid,
    output logic [31:0] core0_rdata,
    output logic        core0_rsp_err,

    input  logic        core1_req_valid,
    output logic        core1_req_ready,
    input  logic [31:0] core1_addr,
    input  logic [31:0] core1_wdata,
    input  logic [2:0]  core1_funct3,
    input  logic        core1_we,
    input  logic        core1_lock,
    output logic        core1_rsp_valid,
    output logic [31:0] core1_rdata,
    output logic        core1_rsp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        owner,
    output logic        locked
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic          lock_q;
    logic          owner_q;
    logic          last_grant_q;
    logic          locked_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [1:0]    rsp_valid_q;
    logic          mem_read_q;
    logic          mem_write_q;

    // Per-core request view, indexed by core number
    logic [1:0]    req_valid;
    logic [1:0]    req_we;
    logic [1:0]    req_lock;
    logic [31:0]   req_addr   [2];
    logic [31:0]   req_wdata  [2];
    logic [2:0]    req_funct3 [2];
    logic [1:0]    eligible;
    logic [1:0]    req_ready;
    logic          grant_sel_d;
    logic [CW-1:0] cnt_d;

    assign req_valid     = {core1_req_valid, core0_req_valid};
    assign req_we        = {core1_we, core0_we};
    assign req_lock      = {core1_lock, core0_lock};
    assign req_addr[0]   = core0_addr;
    assign req_addr[1]   = core1_addr;
    assign req_wdata[0]  = core0_wdata;
    assign req_wdata[1]  = core1_wdata;
    assign req_funct3[0] = core0_funct3;
    assign req_funct3[1] = core1_funct3;

    // A core wins a tie only if it was not the previous winner
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            assign eligible[gi]  = req_valid[gi] & (~locked_q | (owner_q == 1'(gi)));
            assign req_ready[gi] = (state_q == S_IDLE) & eligible[gi]
                                 & (~eligible[1-gi] | (last_grant_q != 1'(gi)));
        end
    endgenerate

    always_comb begin
        grant_sel_d = req_ready[1];
        cnt_d       = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            lock_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            locked_q     <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|req_ready) begin
                        addr_q       <= req_addr[grant_sel_d];
                        wdata_q      <= req_wdata[grant_sel_d];
                        funct3_q     <= req_funct3[grant_sel_d];
                        we_q         <= req_we[grant_sel_d];
                        lock_q       <= req_lock[grant_sel_d];
                        owner_q      <= grant_sel_d;
                        last_grant_q <= grant_sel_d;
                        mem_read_q   <= ~req_we[grant_sel_d];
                        mem_write_q  <= req_we[grant_sel_d];
                        cnt_q        <= '0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // An ack on the last allowed cycle still counts as success
                    if (mem_ack) begin
                        rdata_q     <= we_q ? 32'h0 : mem_rdata;
                        err_q       <= 1'b0;
                        locked_q    <= lock_q;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q     <= 32'h0;
                        err_q       <= 1'b1;
                        locked_q    <= 1'b0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core0_req_ready = req_ready[0];
    assign core1_req_ready = req_ready[1];
    assign core0_rsp_valid = rsp_valid_q[0];
    assign core1_rsp_valid = rsp_valid_q[1];
    assign core0_rdata     = rdata_q;
    assign core1_rdata     = rdata_q;
    assign core0_rsp_err   = err_q;
    assign core1_rsp_err   = err_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_funct3      = funct3_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign owner           = owner_q;
    assign locked          = locked_q;

endmodule
